vga_timing_checker: RTL

Sink-side checker for the VGA pixel stream the design drives onto the PMOD connectors. It samples hs, vs and the 12-bit RGB bus in the pixel clock domain and measures line period, sync widths and lines per frame against 640x480@60 timing. It declares lock after consecutive good frames and produces a per-frame pixel checksum. It sits on a loopback from the PMOD outputs (or directly on the VGA generator's outputs) for on-board self-test and simulation scoreboarding.

---
 rtl/vga_timing_checker.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_checker.sv
// rtl/vga_timing_checker.sv - VGA sink timing checker with lock FSM and per-frame pixel checksum
module vga_timing_checker #(
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int H_ACTIVE        = 640,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int V_ACTIVE        = 480,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        clr_err,
  output logic        locked,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic        err_h,
  output logic        err_v
);

  localparam logic [12:0] LP_HTOT  = 13'(H_TOTAL);
  localparam logic [11:0] LP_HSYNC = 12'(H_SYNC);
  localparam logic [11:0] LP_H_LO  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] LP_H_HI  = 12'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [10:0] LP_VTOT  = 11'(V_TOTAL);
  localparam logic [10:0] LP_VSYNC = 11'(V_SYNC);
  localparam logic [10:0] LP_V_LO  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] LP_V_HI  = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [3:0]  LP_LOCK  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_good_cnt, w_good_next, w_good_inc;

  logic        r_hs_act, r_hs_act_d, r_vs_act, r_vs_act_d, r_clr;
  logic [11:0] r_rgb, r_rgb_d;
  logic [11:0] r_hcnt, r_hw;
  logic [10:0] r_vcnt, r_lines, r_vw;
  logic        r_h_seen, r_frame_bad;
  logic [31:0] r_acc;

  logic        w_hs_in, w_vs_in, w_hs_start, w_hs_fall, w_vs_start;
  logic        w_in_search, w_sat, w_hper_err, w_hw_err, w_line_err;
  logic        w_frame_err, w_frame_end, w_frame_good, w_active;
  logic [12:0] w_hcnt_p1;
  logic [10:0] w_lines;

  assign w_hs_in     = (SYNC_ACTIVE_LOW != 0) ? ~hs : hs;
  assign w_vs_in     = (SYNC_ACTIVE_LOW != 0) ? ~vs : vs;
  assign w_hs_start  = r_hs_act & ~r_hs_act_d;
  assign w_hs_fall   = ~r_hs_act & r_hs_act_d;
  assign w_vs_start  = r_vs_act & ~r_vs_act_d;
  assign w_in_search = (r_state == S_SEARCH);

  assign w_hcnt_p1   = {1'b0, r_hcnt} + 13'd1;
  assign w_sat       = (r_hcnt == 12'd4094) && !w_hs_start;
  assign w_hper_err  = w_hs_start && r_h_seen && !w_in_search && (w_hcnt_p1 != LP_HTOT);
  // Partial pulses around reset release are only possible while still searching.
  assign w_hw_err    = w_hs_fall && !w_in_search && (r_hw != LP_HSYNC);
  assign w_line_err  = w_hper_err | w_hw_err;

  assign w_lines      = r_lines + {10'd0, w_hs_start};
  assign w_frame_end  = w_vs_start && !w_in_search;
  assign w_frame_err  = w_frame_end && ((w_lines != LP_VTOT) || (r_vw != LP_VSYNC));
  assign w_frame_good = !(r_frame_bad || w_line_err || w_frame_err);

  assign w_active = (r_hcnt >= LP_H_LO) && (r_hcnt <= LP_H_HI) &&
                    (r_vcnt >= LP_V_LO) && (r_vcnt <= LP_V_HI);

  assign w_good_inc = r_good_cnt + 4'd1;
  assign locked     = (r_state == S_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_SEARCH;
      r_good_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    case (r_state)
      S_SEARCH: begin
        if (w_vs_start) begin
          w_state_next = S_MEASURE;
          w_good_next  = 4'd0;
        end
      end
      S_MEASURE: begin
        if (w_frame_end) begin
          if (w_frame_good) begin
            w_good_next = w_good_inc;
            if (w_good_inc >= LP_LOCK) w_state_next = S_LOCKED;
          end else begin
            w_good_next = 4'd0;
          end
        end
      end
      S_LOCKED: begin
        if (w_line_err || (w_frame_end && !w_frame_good)) begin
          w_state_next = S_MEASURE;
          w_good_next  = 4'd0;
        end
      end
      default: begin
        w_state_next = S_SEARCH;
        w_good_next  = 4'd0;
      end
    endcase
    if (w_sat) begin
      w_state_next = S_SEARCH;
      w_good_next  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_act    <= 1'b0;
      r_hs_act_d  <= 1'b0;
      r_vs_act    <= 1'b0;
      r_vs_act_d  <= 1'b0;
      r_clr       <= 1'b0;
      r_rgb       <= 12'd0;
      r_rgb_d     <= 12'd0;
      r_hcnt      <= 12'd0;
      r_hw        <= 12'd0;
      r_vcnt      <= 11'd0;
      r_lines     <= 11'd0;
      r_vw        <= 11'd0;
      r_h_seen    <= 1'b0;
      r_frame_bad <= 1'b0;
      r_acc       <= 32'd0;
      frame_done  <= 1'b0;
      frame_sum   <= 32'd0;
      line_len    <= 12'd0;
      frame_lines <= 11'd0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
    end else begin
      r_hs_act   <= w_hs_in;
      r_hs_act_d <= r_hs_act;
      r_vs_act   <= w_vs_in;
      r_vs_act_d <= r_vs_act;
      r_clr      <= clr_err;
      r_rgb      <= {r, g, b};
      // Second stage lines the pixel up with hcnt, which restarts one cycle after hs_start.
      r_rgb_d    <= r_rgb;

      if (w_hs_start)              r_hcnt <= 12'd0;
      else if (r_hcnt != 12'hFFF)  r_hcnt <= r_hcnt + 12'd1;

      if (w_hs_start)                         r_hw <= 12'd1;
      else if (r_hs_act && r_hw != 12'hFFF)   r_hw <= r_hw + 12'd1;

      if ((w_in_search && !w_vs_start) || w_sat) r_h_seen <= 1'b0;
      else if (w_hs_start)                       r_h_seen <= 1'b1;

      if (w_hs_start && r_h_seen && !w_in_search) line_len <= w_hcnt_p1[11:0];

      if (w_vs_start)                             r_vcnt <= 11'd0;
      else if (w_hs_start && r_vcnt != 11'h7FF)   r_vcnt <= r_vcnt + 11'd1;

      if (w_vs_start)                             r_lines <= 11'd0;
      else if (w_hs_start && r_lines != 11'h7FF)  r_lines <= r_lines + 11'd1;

      if (w_vs_start)                                     r_vw <= 11'd1;
      else if (w_hs_start && r_vs_act && r_vw != 11'h7FF) r_vw <= r_vw + 11'd1;

      if (w_vs_start || w_in_search) r_frame_bad <= 1'b0;
      else if (w_line_err)           r_frame_bad <= 1'b1;

      if (w_in_search || w_frame_end) r_acc <= 32'd0;
      else if (w_active)              r_acc <= r_acc + {20'd0, r_rgb_d};

      frame_done <= w_frame_end;
      if (w_frame_end) begin
        frame_sum   <= r_acc;
        frame_lines <= w_lines;
      end

      // A new error in the clear cycle wins over the clear.
      if (w_line_err || w_sat) err_h <= 1'b1;
      else if (r_clr)          err_h <= 1'b0;

      if (w_frame_err)         err_v <= 1'b1;
      else if (r_clr)          err_v <= 1'b0;
    end
  end

endmodule
